// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter for three masters with HLOCK support and a per-tenure beat limit.
// Latency: a request seen at a rearbitration point is granted at the next HCLK edge.
// Backpressure: HREADY_S=0 freezes every register (grant, FSM, counter, pointer, data-phase owner).
//
// Ports:
//   HCLK, HRESET        bus clock, synchronous active-high reset
//   HBUSREQ, HLOCK      per-master request and locked-transfer request (bit i = master i)
//   HTRANS_S, HREADY_S  muxed HTRANS of the address-phase owner and muxed slave HREADY
//   HGRANT, HMASTER     one-hot grant and encoded address-phase owner
//   HMASTER_D           data-phase owner (HWDATA mux select)
//   HMASTLOCK           current address-phase transfer is locked
module ahb_rr_arbiter #(
    parameter int TENURE_MAX     = 16,
    parameter int DEFAULT_MASTER = 1,
    parameter int CNT_W          = 8
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [2:0] HBUSREQ,
    input  logic [2:0] HLOCK,
    input  logic [1:0] HTRANS_S,
    input  logic       HREADY_S,
    output logic [2:0] HGRANT,
    output logic [1:0] HMASTER,
    output logic [1:0] HMASTER_D,
    output logic       HMASTLOCK
);

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWNED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       mst_q, mst_d;
    logic [1:0]       mst_dp_q, mst_dp_d;
    logic             lock_q, lock_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       beat;
    logic       exhausted;
    logic       rearb;
    logic [1:0] cand1, cand2;
    logic [1:0] winner;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign beat      = HTRANS_S[1];
    assign exhausted = (cnt_q == CNT_W'(TENURE_MAX));

    // Pre-emption only at IDLE, or at the NONSEQ that starts a new burst once
    // the tenure is used up; BUSY/SEQ never break a burst in flight.
    assign rearb = (state_q != LOCKED) && !HLOCK[mst_q] &&
                   ((HTRANS_S == TR_IDLE) || ((HTRANS_S == TR_NONSEQ) && exhausted));

    // Search order ptr+1, ptr+2, ptr: the current owner is considered last.
    assign cand1 = inc3(ptr_q);
    assign cand2 = inc3(cand1);

    always_comb begin
        winner = 2'(DEFAULT_MASTER);
        if (HBUSREQ[cand1]) begin
            winner = cand1;
        end else if (HBUSREQ[cand2]) begin
            winner = cand2;
        end else if (HBUSREQ[ptr_q]) begin
            winner = ptr_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        mst_d    = mst_q;
        mst_dp_d = mst_dp_q;
        lock_d   = lock_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        if (HREADY_S) begin
            // Data phase follows the address phase accepted this cycle.
            mst_dp_d = mst_q;
            lock_d   = HLOCK[mst_q];
            if (rearb) begin
                // Tenure restarts even when the same master wins again.
                grant_d = 3'b001 << winner;
                mst_d   = winner;
                ptr_d   = winner;
                cnt_d   = '0;
                state_d = HBUSREQ[winner] ? OWNED : PARK;
            end else begin
                if (beat && !exhausted) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (HLOCK[mst_q]) begin
                    state_d = LOCKED;
                end else if (HBUSREQ[mst_q]) begin
                    state_d = OWNED;
                end else begin
                    state_d = PARK;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= PARK;
            grant_q  <= 3'b001 << 2'(DEFAULT_MASTER);
            mst_q    <= 2'(DEFAULT_MASTER);
            mst_dp_q <= 2'(DEFAULT_MASTER);
            lock_q   <= 1'b0;
            ptr_q    <= 2'(DEFAULT_MASTER);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            mst_q    <= mst_d;
            mst_dp_q <= mst_dp_d;
            lock_q   <= lock_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = mst_q;
    assign HMASTER_D = mst_dp_q;
    assign HMASTLOCK = lock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: directed scenarios followed by randomized traffic.
// Latency: outputs compared 1 time unit after each rising HCLK edge.
// Backpressure: HREADY_S driven both high and low to exercise hold behaviour.
module tb_ahb_rr_arbiter;

    localparam int TM = 4;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [2:0] HBUSREQ;
    logic [2:0] HLOCK;
    logic [1:0] HTRANS_S;
    logic       HREADY_S;
    logic [2:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;

    ahb_rr_arbiter #(.TENURE_MAX(TM), .DEFAULT_MASTER(1), .CNT_W(8)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS_S  (HTRANS_S),
        .HREADY_S  (HREADY_S),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    int errs   = 0;
    int checks = 0;

    // Reference model: who owns the bus, beats used in this tenure, lock hold.
    int m_owner  = 1;
    int m_cnt    = 0;
    bit m_locked = 1'b0;
    int m_md     = 1;
    bit m_ml     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int own, input logic [2:0] req);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (own + k) % 3;
            if (req[c]) return c;
        end
        return 1;
    endfunction

    task automatic tick();
        int own;
        bit rearb;
        logic [2:0] eg;
        @(posedge HCLK);
        if (HRESET) begin
            m_owner = 1; m_cnt = 0; m_locked = 1'b0; m_md = 1; m_ml = 1'b0;
        end else if (HREADY_S) begin
            own   = m_owner;
            m_ml  = HLOCK[own];
            m_md  = own;
            rearb = !m_locked && !HLOCK[own] &&
                    (HTRANS_S == 2'b00 || (HTRANS_S == 2'b10 && m_cnt == TM));
            if (rearb) begin
                m_owner  = rr_pick(own, HBUSREQ);
                m_cnt    = 0;
                m_locked = 1'b0;
            end else begin
                if (HTRANS_S[1] && m_cnt < TM) m_cnt++;
                m_locked = HLOCK[own];
            end
        end
        #1;
        eg = 3'(1 << m_owner);
        chk("hgrant",    HGRANT, eg);
        chk("hmaster",   HMASTER, m_owner);
        chk("hmaster_d", HMASTER_D, m_md);
        chk("hmastlock", HMASTLOCK, m_ml);
        chk("onehot",    $onehot(HGRANT), 1);
    endtask

    initial begin
        int rr_exp [6];
        rr_exp = '{2, 0, 1, 2, 0, 1};

        HRESET = 1'b1; HBUSREQ = 3'b000; HLOCK = 3'b000; HTRANS_S = 2'b00; HREADY_S = 1'b1;
        tick(); tick();
        chk("reset_grant", HGRANT, 3'b010);
        chk("reset_lock",  HMASTLOCK, 0);
        HRESET = 1'b0;

        // Park on the default master with nobody requesting.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("park_grant", HGRANT, 3'b010);
        end

        // All masters requesting at IDLE: grant rotates every cycle.
        HBUSREQ = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_seq", HMASTER, rr_exp[i]);
        end

        // Tenure pre-emption: M0 bursts, M1 waits for the exhausted NONSEQ.
        HBUSREQ = 3'b001; HTRANS_S = 2'b00;
        tick();
        chk("take_m0", HGRANT, 3'b001);
        HBUSREQ = 3'b011;
        HTRANS_S = 2'b10; tick();
        HTRANS_S = 2'b11; tick(); tick(); tick();
        chk("tenure_hold", HGRANT, 3'b001);
        HTRANS_S = 2'b10; tick();
        chk("tenure_preempt", HGRANT, 3'b010);
        HBUSREQ = 3'b010; HTRANS_S = 2'b11; tick();
        chk("tenure_data_owner", HMASTER_D, 1);

        // Locked M2 holds the bus through IDLEs while others request.
        HBUSREQ = 3'b100; HTRANS_S = 2'b00; tick();
        HBUSREQ = 3'b111; HLOCK = 3'b100;
        for (int i = 0; i < 40; i++) begin
            HTRANS_S = 2'($urandom_range(0, 3));
            tick();
            chk("lock_grant", HGRANT, 3'b100);
            chk("lock_mastlock", HMASTLOCK, 1);
        end
        HLOCK = 3'b000; HTRANS_S = 2'b00; tick();
        chk("lock_exit_hold", HGRANT, 3'b100);
        tick();
        chk("lock_release", HGRANT, 3'b001);

        // Wait states at an IDLE during an M0 tenure.
        HBUSREQ = 3'b001; tick();
        HBUSREQ = 3'b011; HTRANS_S = 2'b10; tick();
        HTRANS_S = 2'b00; HREADY_S = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_grant", HGRANT, 3'b001);
            chk("wait_data_owner", HMASTER_D, 0);
        end
        HREADY_S = 1'b1; tick();
        chk("wait_release", HGRANT, 3'b010);

        // Reset in the middle of an M0 burst.
        HBUSREQ = 3'b001; HTRANS_S = 2'b00; tick();
        HTRANS_S = 2'b10; tick();
        HTRANS_S = 2'b11; tick(); tick();
        HRESET = 1'b1; tick();
        chk("midreset_grant", HGRANT, 3'b010);
        chk("midreset_lock", HMASTLOCK, 0);
        HRESET = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            HRESET   = ($urandom_range(0, 99) == 0);
            HBUSREQ  = 3'($urandom);
            HLOCK    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            HTRANS_S = 2'($urandom);
            HREADY_S = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
- Round-robin AHB bus arbiter for three masters, with HLOCK support and a per-tenure beat limit.
- Drives the one-hot grants that steer the shared address/control mux and the write-data mux.
- Supplies address-phase and data-phase owner indices for those muxes and for slave HMASTER/HMASTLOCK.
- Prevents any unlocked master from starving the others with back-to-back bursts.

Parameters:
- TENURE_MAX, 16: number of accepted NONSEQ/SEQ beats after which the owner becomes pre-emptible at its next NONSEQ. Legal range 1..255.
- DEFAULT_MASTER, 1: master index (0..2) parked on when no master requests.
- CNT_W, 8: tenure counter width. Must satisfy 2^CNT_W > TENURE_MAX.

Ports:
- HCLK  input  1  bus clock; all state updates on rising edge.
- HRESET  input  1  synchronous, active-high reset. It is sampled on the HCLK rising edge only.
- HBUSREQ  input  3  bus request; bit i belongs to master i.
- HLOCK  input  3  locked-transfer request; bit i belongs to master i.
- HTRANS_S  input  2  muxed HTRANS of the current address-phase owner. Encoding: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY_S  input  1  muxed slave HREADY.
- HGRANT  output  3  one-hot grant, registered.
- HMASTER  output  2  index of the address-phase owner (encoded HGRANT), registered.
- HMASTER_D  output  2  index of the data-phase owner, used for HWDATA muxing, registered.
- HMASTLOCK  output  1  current address-phase transfer is locked, registered.

Behaviour:
- Reset (HRESET=1 at a clock edge), outputs: HGRANT=3'b010, HMASTER=1, HMASTER_D=1, HMASTLOCK=0.
- Reset, internal state: tenure counter=0, RR pointer=1, FSM=PARK.
- Reset wins over every other event in the same cycle. Asserting reset mid-burst returns to the reset state at that edge; there is no draining.
- HREADY_S=0: all registers hold, including FSM, counter, pointer and outputs.
- Beat: a cycle with HREADY_S=1 and HTRANS_S in {NONSEQ, SEQ}.
- Tenure counter:
  - clears to 0 on every grant change;
  - otherwise increments on each beat;
  - saturates at TENURE_MAX;
  - holds at TENURE_MAX while LOCKED.
- Exhausted: counter == TENURE_MAX.
- FSM states:
  - PARK: granted master is not requesting.
  - OWNED: granted master requesting, HLOCK of owner = 0.
  - LOCKED: HLOCK[owner] = 1.
- Rearbitration point, all conditions required:
  - HREADY_S=1;
  - FSM != LOCKED and HLOCK[owner]=0;
  - either HTRANS_S==IDLE, or (HTRANS_S==NONSEQ and exhausted).
- BUSY or SEQ is never a rearbitration point.
- Winner at a rearbitration point:
  - first requesting master in the order (ptr+1, ptr+2, ptr) mod 3, where ptr is the current owner;
  - if HBUSREQ==0, the winner is DEFAULT_MASTER.
- Grant update: HGRANT/HMASTER take the winner at the next edge; ptr takes the winner.
- If the winner equals the current owner, the counter still clears, because the tenure restarts.
- Pre-emption at NONSEQ: the NONSEQ presented this cycle completes under the old owner. Further beats of that burst are the old master's responsibility to re-issue (AHB early burst termination).
- HMASTLOCK updates when HREADY_S=1: value is HLOCK[HMASTER] for the owner presenting the address phase this cycle.
- LOCKED entry and exit:
  - enter when HREADY_S=1 and HLOCK[owner]=1;
  - exit to OWNED/PARK when HREADY_S=1 and HLOCK[owner]=0;
  - the first rearbitration point is no earlier than the cycle after exit.
- OWNED/PARK transitions: OWNED -> PARK when HBUSREQ[owner]=0; PARK -> OWNED when HBUSREQ[owner]=1. Both are evaluated with HREADY_S=1.
- HMASTER_D: takes HMASTER on every edge with HREADY_S=1. This gives one accepted address phase of lag behind HMASTER.
- Simultaneous requests: resolved purely by RR order from ptr. There is no fixed priority.
- Latency: a request arriving at an IDLE point is granted at the next edge (1 cycle). Worst-case wait for an unlocked competitor is 2*(TENURE_MAX + max burst remainder) beats.
- HGRANT is always one-hot, including immediately after reset.

Test Plan:
- Reset and park: HRESET=1 for 2 cycles, then HBUSREQ=0, HTRANS_S=IDLE, HREADY_S=1 → HGRANT=010, HMASTER=1, HMASTER_D=1, HMASTLOCK=0, held every cycle.
- Round robin: HBUSREQ=111, HTRANS_S=IDLE, HREADY_S=1 continuously → HGRANT sequence 100, 001, 010, 100, … (owner 1 → 2 → 0 → 1), one change per cycle.
- Tenure pre-emption, TENURE_MAX=4: M0 owns and issues INCR NONSEQ,SEQ×3,NONSEQ,…; M1 requesting → counter reaches 4 after 4 beats; at the next NONSEQ with HREADY_S=1, HGRANT=010 at the following edge; HMASTER_D follows one accepted cycle later.
- Lock hold: M2 owns with HLOCK[2]=1 for 40 beats, including IDLEs; M0 and M1 requesting → HGRANT stays 100 and HMASTLOCK=1 throughout. After HLOCK[2]=0 and the next IDLE, HGRANT becomes 001.
- Wait states: during an M0 burst with M1 requesting, HREADY_S=0 for 5 cycles at an IDLE → no grant, counter or HMASTER_D change until HREADY_S=1, then HGRANT=010 one edge later.
- Reset mid-burst: M0 owns, counter=3, HTRANS_S=SEQ, HRESET=1 for one edge → HGRANT=010, counter 0, HMASTLOCK=0 immediately after that edge.
